seq_shift_right_32: RTL and testbench
=====================================

Name: seq_shift_right_32

Overview:
- Multi-cycle right shifter for the CPU's SRL/SRA path. It is the reverse direction of the existing left-shift-by-two path, e.g. recovering a word index from a byte offset.
- Accepts one operand per start handshake and shifts one bit per clock. Supports logical and arithmetic modes.
- Raises a one-cycle done pulse with the result held stable afterwards. Sits beside the ALU and stalls the pipeline on busy_o.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHAMT_WIDTH, 5, shift-amount width; must equal log2(DATA_WIDTH).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  request; accepted only while ready_o=1.
- data_i  input  DATA_WIDTH  operand, sampled on the accept edge.
- shamt_i  input  SHAMT_WIDTH  shift amount, sampled on the accept edge.
- arith_i  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); sampled on the accept edge.
- ready_o  output  1  high in IDLE only.
- busy_o  output  1  high in SHIFT or DONE.
- done_o  output  1  one-cycle pulse in DONE.
- data_o  output  DATA_WIDTH  result register.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: state=IDLE, result reg=0, count=0, fill bit=0. Outputs: ready_o=1, busy_o=0, done_o=0, data_o=0.
- Reset asserted mid-operation aborts immediately to these values. No done_o pulse occurs.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - ready_o=1. On a clock edge with start_i=1 (accept edge): reg<=data_i, count<=shamt_i, fill<=arith_i & data_i[DATA_WIDTH-1].
  - Next state is DONE if shamt_i==0, else SHIFT.
  - With start_i=0, stay in IDLE; reg holds.
- SHIFT:
  - Each edge: reg<={fill, reg[DATA_WIDTH-1:1]}, count<=count-1.
  - If count==1 at the edge, next state is DONE.
- DONE:
  - done_o=1 for exactly this cycle; data_o carries the final result.
  - Next edge goes to IDLE unconditionally.
- Latency: done_o is high in cycle N+1 after the accept edge, N = shamt_i (range 0..31). Accept-to-accept throughput is N+2 cycles.
- data_o = reg at all times. It is valid from DONE until the next accept edge, and changes during SHIFT; consumers sample only on done_o.
- start_i while busy (SHIFT/DONE) is ignored and is not queued. data_i, shamt_i and arith_i may change freely after the accept edge.
- start_i in the same cycle as a DONE→IDLE transition is not accepted. Acceptance requires state==IDLE at that edge.
- Arithmetic rules:
  - Result = data_i >> N (logical) or data_i >>> N (arithmetic).
  - The fill bit is captured once, so the sign is preserved across all N steps.
  - N=31 arithmetic on a negative operand gives all ones.
- No combinational path from inputs to outputs. ready_o, busy_o and done_o decode from the state register only.

Decomposition:
- Shared package (cpu_pkg): FSM state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2). It also holds the DATA_WIDTH/SHAMT_WIDTH defaults, kept consistent with the ALU.
- One natural sub-module: shift_right_one_32. It is a combinational single-bit right shift with fill input, instantiated in the SHIFT datapath.
- All remaining logic (FSM, counter, registers) stays in seq_shift_right_32.

Test Plan:
- Reset, then start with data_i=0x80000000, shamt_i=4, arith_i=1 → done_o high exactly 5 cycles after the accept edge, data_o=0xF8000000. Repeat with arith_i=0 → data_o=0x08000000.
- data_i=0x00000100, shamt_i=2, arith_i=0 → data_o=0x00000040 with done_o at cycle 3. This is the word index of byte offset 0x100.
- data_i=0x12345678, shamt_i=0 → done_o in cycle 1 after accept, data_o=0x12345678, ready_o back high the next cycle.
- data_i=0x80000000, shamt_i=31, arith_i=1 → data_o=0xFFFFFFFF at cycle 32. With arith_i=0 → 0x00000001.
- Start a 10-bit shift, then pulse start_i with different data at cycles 3 and 11 (the DONE cycle) → both ignored; the result matches the first operand only, and only one done_o pulse occurs.
- Start a 20-bit shift and assert rst_i asynchronously (mid-cycle) at cycle 7 → outputs go to reset values immediately with no done_o. After release, a new shamt_i=1 request completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the sequential shifter's state encoding.
package cpu_pkg;

  // Defaults shared with the ALU so the shifter and ALU operands stay the same width.
  localparam int DATA_WIDTH  = 32;
  localparam int SHAMT_WIDTH = 5;

  // Sequential shifter FSM encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

endpackage

// File: rtl/shift_right_one_32.sv
// Combinational one-bit right shift; the vacated MSB takes the supplied fill bit.
module shift_right_one_32
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  // Drop the LSB and insert the fill bit at the top.
  assign result = {fill, data[WIDTH-1:1]};

endmodule

// File: rtl/seq_shift_right_32.sv
// Multi-cycle logical/arithmetic right shifter, one bit per clock, for the SRL/SRA path.
// The fill bit is captured once at accept, so the sign is preserved over every step.
module seq_shift_right_32
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH  = cpu_pkg::DATA_WIDTH,
  parameter int SHAMT_WIDTH = cpu_pkg::SHAMT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  input  logic                   arith_i,
  output logic                   ready_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  data_o
);

  localparam logic [SHAMT_WIDTH-1:0] COUNT_ONE  = SHAMT_WIDTH'(1);
  localparam logic [SHAMT_WIDTH-1:0] COUNT_ZERO = '0;

  shift_state_e            state;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [SHAMT_WIDTH-1:0]  count;
  logic                    fill;
  logic [DATA_WIDTH-1:0]   shift_next;

  // Single-step shift of the working register.
  shift_right_one_32 #(
    .WIDTH (DATA_WIDTH)
  ) u_shift_one (
    .data   (shift_reg),
    .fill   (fill),
    .result (shift_next)
  );

  // FSM, shift register, step counter and fill bit.
  // NOTE: every register here uses non-blocking assignments so all of them update
  // from the same pre-edge values; a blocking write would leak into later reads.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: reset aborts an operation in flight; clearing the datapath as well
      // as the state keeps data_o deterministic and avoids a stray done pulse.
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
      fill      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            shift_reg <= data_i;
            count     <= shamt_i;
            fill      <= arith_i & data_i[DATA_WIDTH-1];
            state     <= (shamt_i == COUNT_ZERO) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= shift_next;
          count     <= count - COUNT_ONE;
          if (count == COUNT_ONE) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status decodes come only from the state register; no input reaches an output.
  assign ready_o = (state == IDLE);
  assign busy_o  = (state == SHIFT) || (state == DONE);
  assign done_o  = (state == DONE);
  assign data_o  = shift_reg;

endmodule

// File: tb/tb_seq_shift_right_32.sv
// Self-checking bench for seq_shift_right_32: directed cases plus random operands
// compared against a plain-arithmetic shift model.
module tb_seq_shift_right_32;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [31:0] data_i;
  logic [4:0]  shamt_i;
  logic        arith_i;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] data_o;

  int checks = 0;
  int errors = 0;

  seq_shift_right_32 dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .data_i  (data_i),
    .shamt_i (shamt_i),
    .arith_i (arith_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .data_o  (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: the result is just the operand shifted by N, signed or unsigned.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int n, input bit a);
    logic signed [31:0] s;
    s = d;
    if (a) return 32'(s >>> n);
    return d >> n;
  endfunction

  // Issue one request and check latency, result and the return to idle.
  // Entered #1 after a rising edge. With inject set, extra start pulses are driven
  // in cycle 3 and in the done cycle; both must be ignored.
  task automatic run_op(input logic [31:0] d, input int n, input bit a,
                        input bit inject, input string tag);
    logic [31:0] exp;
    int c;
    int w;
    exp = ref_shift(d, n, a);
    w = 0;
    while (!ready_o && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
    start_i = 1'b1;
    data_i  = d;
    shamt_i = 5'(n);
    arith_i = a;
    @(posedge clk); #1;
    // Operands may change freely after the accept edge.
    start_i = 1'b0;
    data_i  = $urandom;
    shamt_i = 5'($urandom_range(0, 31));
    arith_i = 1'($urandom_range(0, 1));
    c = 1;
    check({tag, "_busy"}, {30'd0, busy_o, ready_o}, 32'b10);
    while (!done_o && c < 40) begin
      if (inject && c == 3) begin
        start_i = 1'b1;
        data_i  = $urandom;
        shamt_i = 5'd0;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      c++;
    end
    start_i = 1'b0;
    check({tag, "_done_seen"}, {31'd0, done_o}, 32'd1);
    check({tag, "_latency"}, 32'(c), 32'(n + 1));
    check({tag, "_result"}, data_o, exp);
    if (inject) begin
      start_i = 1'b1;
      data_i  = $urandom;
      shamt_i = 5'd0;
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    check({tag, "_idle_after"}, {29'd0, ready_o, busy_o, done_o}, 32'b100);
    check({tag, "_hold"}, data_o, exp);
    @(posedge clk); #1;
    check({tag, "_no_requeue"}, {29'd0, ready_o, busy_o, done_o}, 32'b100);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int c;
    rst_i   = 1'b1;
    start_i = 1'b0;
    data_i  = '0;
    shamt_i = '0;
    arith_i = 1'b0;
    #12;
    check("reset_status", {29'd0, ready_o, busy_o, done_o}, 32'b100);
    check("reset_data", data_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    run_op(32'h8000_0000, 4,  1'b1, 1'b0, "sra4");
    run_op(32'h8000_0000, 4,  1'b0, 1'b0, "srl4");
    run_op(32'h0000_0100, 2,  1'b0, 1'b0, "word_idx");
    run_op(32'h1234_5678, 0,  1'b0, 1'b0, "zero_shift");
    run_op(32'h8000_0000, 31, 1'b1, 1'b0, "sra31");
    run_op(32'h8000_0000, 31, 1'b0, 1'b0, "srl31");
    check("sra31_model", ref_shift(32'h8000_0000, 31, 1'b1), 32'hFFFF_FFFF);
    run_op(32'hA5C3_0F81, 10, 1'b1, 1'b1, "busy_start");

    // Asynchronous reset in the middle of a 20-bit shift.
    start_i = 1'b1;
    data_i  = 32'hF00D_BEEF;
    shamt_i = 5'd20;
    arith_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    c = 1;
    while (c < 7) begin
      @(posedge clk); #1; c++;
    end
    check("pre_reset_busy", {31'd0, busy_o}, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_reset_status", {29'd0, ready_o, busy_o, done_o}, 32'b100);
    check("async_reset_data", data_o, 32'd0);
    @(posedge clk); #1;
    check("reset_held_nodone", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", {29'd0, ready_o, busy_o, done_o}, 32'b100);
    run_op(32'hC000_0003, 1, 1'b1, 1'b0, "after_reset");

    // Random operands against the model.
    for (int i = 0; i < 40; i++) begin
      run_op($urandom, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
